seg7_scan_ctrl: RTL and testbench

Time-multiplexing controller for the board's 8-digit common-anode seven-segment display. Holds a 32-bit hex value plus per-digit decimal-point and blink-select bits, and cycles one digit at a time. For each digit it drives the 4-bit nibble, point and LES inputs of the hex-to-segment decoder, a shared `flash` square wave and the active-low anode select. New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/tick_div.sv | 23 ++
 rtl/seg7_scan_ctrl.sv | 86 ++++++++
 tb/tb_seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and display-register layout for the seven-segment scan controller.
package seg7_pkg;
   localparam int NDIG = 8;
   localparam int DIG_W = $clog2(NDIG);
   localparam logic [NDIG-1:0] AN_OFF = 8'hFF;
   localparam int SCAN_DIV_DEF = 50000;
   localparam int BLINK_DIV_DEF = 25000000;

   typedef struct packed {
      logic [4*NDIG-1:0] data;
      logic [NDIG-1:0]   points;
      logic [NDIG-1:0]   les;
   } disp_t;
endpackage

// File: rtl/tick_div.sv
// Modulo-DIV enabled counter; tick is high combinationally in the terminal-count cycle.
// Holds its count while en is low, so tick never fires when disabled.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = en && (cnt == W'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed display scanner; outputs are combinational from registers (0 cycles).
// Loads are shadowed and committed only on the frame boundary; no backpressure on load.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = SCAN_DIV_DEF,
   parameter int BLINK_DIV = BLINK_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] data,
   input  logic [7:0]  points,
   input  logic [7:0]  les,
   output logic [3:0]  Hexs,
   output logic        point,
   output logic        LES,
   output logic        flash,
   output logic [7:0]  AN,
   output logic        pending,
   output logic        frame_tick
);
   logic             scan_tick;
   logic             blink_tick;
   logic             frame;
   logic [DIG_W-1:0] dig;
   logic             flash_r;
   logic             pending_r;
   disp_t            shadow;
   disp_t            disp;
   disp_t            incoming;

   assign incoming = {data, points, les};

   tick_div #(.DIV(SCAN_DIV)) u_scan (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (scan_tick)
   );

   tick_div #(.DIV(BLINK_DIV)) u_blink (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (blink_tick)
   );

   assign frame = scan_tick && (dig == DIG_W'(NDIG - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig       <= '0;
         flash_r   <= 1'b0;
         pending_r <= 1'b0;
         shadow    <= '0;
         disp      <= '0;
      end else begin
         if (scan_tick)
            dig <= dig + 1'b1;
         if (blink_tick)
            flash_r <= ~flash_r;
         if (load)
            shadow <= incoming;
         // A load landing on the boundary bypasses the shadow so it is shown at once.
         if (frame) begin
            pending_r <= 1'b0;
            if (load)
               disp <= incoming;
            else if (pending_r)
               disp <= shadow;
         end else if (load) begin
            pending_r <= 1'b1;
         end
      end
   end

   assign Hexs       = disp.data[{dig, 2'b00} +: 4];
   assign point      = disp.points[dig];
   assign LES        = disp.les[dig];
   assign flash      = flash_r;
   assign AN         = en ? ~(8'b1 << dig) : AN_OFF;
   assign pending    = pending_r;
   assign frame_tick = frame;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus pushes expected observations, monitor pops and compares.
module tb_seg7_scan_ctrl;
   localparam int SD = 4;
   localparam int BD = 16;
   localparam int FR = 8 * SD;

   typedef struct packed {
      logic [7:0] an;
      logic [3:0] hexs;
      logic       point;
      logic       les;
      logic       flash;
      logic       pending;
      logic       ft;
   } obs_t;

   typedef struct {
      int    cyc;
      obs_t  o;
      string tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [31:0] data = '0;
   logic [7:0]  points = '0;
   logic [7:0]  les = '0;
   logic [3:0]  Hexs;
   logic        point;
   logic        LES;
   logic        flash;
   logic [7:0]  AN;
   logic        pending;
   logic        frame_tick;

   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   exp_t  q[$];
   int    ftq[$];
   string tag = "reset";

   // Reference state: every counter is a function of enabled cycles since reset.
   int          m_ec = 0;
   logic [31:0] m_sd = '0, m_dd = '0;
   logic [7:0]  m_sp = '0, m_dp = '0, m_sl = '0, m_dl = '0;
   logic        m_pend = 1'b0;

   seg7_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .data       (data),
      .points     (points),
      .les        (les),
      .Hexs       (Hexs),
      .point      (point),
      .LES        (LES),
      .flash      (flash),
      .AN         (AN),
      .pending    (pending),
      .frame_tick (frame_tick)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input logic r, input logic e, input logic l,
                       input logic [31:0] d, input logic [7:0] p, input logic [7:0] s);
      exp_t x;
      int   dg;
      logic ft;
      rst = r; en = e; load = l; data = d; points = p; les = s;
      if (r) begin
         m_ec = 0; m_sd = '0; m_dd = '0; m_sp = '0; m_dp = '0;
         m_sl = '0; m_dl = '0; m_pend = 1'b0;
      end
      dg = (m_ec / SD) % 8;
      ft = !r && e && (m_ec % FR == FR - 1);
      x.cyc       = cyc;
      x.tag       = tag;
      x.o.an      = e ? ~(8'h01 << dg) : 8'hFF;
      x.o.hexs    = 4'(m_dd >> (4 * dg));
      x.o.point   = m_dp[dg];
      x.o.les     = m_dl[dg];
      x.o.flash   = 1'((m_ec / BD) % 2);
      x.o.pending = m_pend;
      x.o.ft      = ft;
      q.push_back(x);
      if (ft) ftq.push_back(cyc);
      if (!r) begin
         if (l) begin
            m_sd = d; m_sp = p; m_sl = s;
         end
         if (ft) begin
            if (l) begin
               m_dd = d; m_dp = p; m_dl = s;
            end else if (m_pend) begin
               m_dd = m_sd; m_dp = m_sp; m_dl = m_sl;
            end
            m_pend = 1'b0;
         end else if (l) begin
            m_pend = 1'b1;
         end
         if (e) m_ec++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic e);
      repeat (n) step(1'b0, e, 1'b0, 32'h0, 8'h0, 8'h0);
   endtask

   always @(negedge clk) begin
      obs_t a;
      exp_t x;
      int   t;
      a = {AN, Hexs, point, LES, flash, pending, frame_tick};
      if (q.size() > 0 && q[0].cyc == cyc) begin
         x = q.pop_front();
         n_chk++;
         if (a !== x.o) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got an=%h hex=%h pt=%b les=%b fl=%b pend=%b ft=%b want an=%h hex=%h pt=%b les=%b fl=%b pend=%b ft=%b",
                     x.tag, cyc, a.an, a.hexs, a.point, a.les, a.flash, a.pending, a.ft,
                     x.o.an, x.o.hexs, x.o.point, x.o.les, x.o.flash, x.o.pending, x.o.ft);
         end
      end
      if (frame_tick === 1'b1) begin
         n_chk++;
         if (ftq.size() == 0) begin
            n_fail++;
            $display("FAIL frame_tick unexpected pulse at cyc=%0d, none expected", cyc);
         end else begin
            t = ftq.pop_front();
            if (t != cyc) begin
               n_fail++;
               $display("FAIL frame_tick at cyc=%0d, required cyc=%0d", cyc, t);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      tag = "reset";
      step(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);

      tag = "scan";
      run(40, 1'b1);

      tag = "load_mid";
      run(5, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h89ABCDEF, 8'h0F, 8'h81);
      run(60, 1'b1);

      tag = "load_boundary";
      while (m_ec % FR != FR - 1) run(1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h01234567, 8'hA5, 8'h3C);
      run(40, 1'b1);

      tag = "double_load";
      run(2, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h11111111, 8'hF0, 8'h00);
      run(10, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h22222222, 8'h55, 8'hAA);
      run(45, 1'b1);

      tag = "enable";
      run(3, 1'b1);
      run(10, 1'b0);
      run(40, 1'b1);

      tag = "reset_mid";
      step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 8'hFF);
      run(5, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
      run(40, 1'b1);
      run(3, 1'b0);

      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain %0d observations left unchecked, required 0", q.size());
      end
      n_chk++;
      if (ftq.size() != 0) begin
         n_fail++;
         $display("FAIL frame_tick %0d expected pulses never seen, required 0", ftq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
